// File: rtl/cmd_router_if.sv
// -----------------------------------------------------------------------------
// cmd_router_if
//   Bundles the command panel inputs and the per-destination outputs of
//   cmd_router.
//
//   master : the panel / testbench side (drives requests, observes outputs)
//   slave  : the router side (consumes requests, drives outputs)
//
//   Signals
//     INCR, DECR, CONF : held request levels from the debounce stage
//     dest_sel         : requested destination index
//     DT               : threshold word delivered on CONF
//     INCR_OUT/DECR_OUT/CONF_OUT : one-hot, single-cycle registered pulses
//     DT_OUT           : per-destination latched DT, channel i at [i*DT_W +: DT_W]
//     active_dest      : committed destination
//     busy             : changeover guard running
//     fsm_state        : debug view of the router FSM (0 = IDLE, 1 = SWITCH)
//
//   Transfer semantics: there is no valid/ready pair. A request is the rising
//   edge of a level input; each accepted request yields exactly one
//   one-cycle pulse on the active destination, with no back-pressure.
// -----------------------------------------------------------------------------
interface cmd_router_if #(
   parameter int N_DEST = 2,
   parameter int SEL_W  = 1,
   parameter int DT_W   = 5
);
   logic                     INCR;
   logic                     DECR;
   logic                     CONF;
   logic [SEL_W-1:0]         dest_sel;
   logic [DT_W-1:0]          DT;
   logic [N_DEST-1:0]        INCR_OUT;
   logic [N_DEST-1:0]        DECR_OUT;
   logic [N_DEST-1:0]        CONF_OUT;
   logic [N_DEST*DT_W-1:0]   DT_OUT;
   logic [SEL_W-1:0]         active_dest;
   logic                     busy;
   logic                     fsm_state;

   modport master (
      output INCR, DECR, CONF, dest_sel, DT,
      input  INCR_OUT, DECR_OUT, CONF_OUT, DT_OUT, active_dest, busy, fsm_state
   );

   modport slave (
      input  INCR, DECR, CONF, dest_sel, DT,
      output INCR_OUT, DECR_OUT, CONF_OUT, DT_OUT, active_dest, busy, fsm_state
   );
endinterface

// File: rtl/cmd_router.sv
// -----------------------------------------------------------------------------
// cmd_router
//   Routes thermostat user commands (INCR, DECR, CONF, DT) from one input
//   panel to one of N_DEST destination cores.
//   - Held command levels become single-cycle registered pulses on the
//     committed destination (active_dest), one cycle after the sampling edge.
//   - CONF loads DT into that destination's DT_OUT slot.
//   - A change of dest_sel starts a GUARD_CYC-cycle changeover (busy high)
//     during which all requests are dropped; the select may retarget or abort
//     while the guard runs.
//
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset
//     bus : cmd_router_if.slave (requests in, pulses / DT / status out)
// -----------------------------------------------------------------------------
module cmd_router #(
   parameter int N_DEST    = 2,
   parameter int SEL_W     = 1,
   parameter int DT_W      = 5,
   parameter int GUARD_CYC = 4
) (
   input  logic         clk,
   input  logic         rst,
   cmd_router_if.slave  bus
);

   localparam int                CNT_W    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GUARD_CYC - 1);
   // One extra bit so N_DEST == 2**SEL_W is representable.
   localparam logic [SEL_W:0]    N_DEST_L = (SEL_W + 1)'(N_DEST);

   typedef enum logic {
      IDLE   = 1'b0,
      SWITCH = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [SEL_W-1:0]         active_q, active_d;
   logic [SEL_W-1:0]         target_q, target_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   // Edge-history registers; reset to 0 so a level held through reset
   // release still produces one pulse.
   logic                     incr_h, decr_h, conf_h;

   logic [N_DEST-1:0]        incr_q, decr_q, conf_q;
   logic [N_DEST*DT_W-1:0]   dt_q;

   logic                     req_incr, req_decr, req_conf;
   logic                     fire_incr, fire_decr, fire_conf;
   logic                     dest_valid, sel_is_active, sel_is_target;
   logic [N_DEST-1:0]        dest_onehot;

   // ---------------------------------------------------------------------------
   // Request detection and acceptance
   // ---------------------------------------------------------------------------
   always_comb begin
      req_incr = bus.INCR & ~incr_h;
      req_decr = bus.DECR & ~decr_h;
      req_conf = bus.CONF & ~conf_h;

      // Requests are only honoured in IDLE. INCR and DECR arriving together
      // cancel each other; CONF is independent of both.
      fire_incr = (state_q == IDLE) & req_incr & ~req_decr;
      fire_decr = (state_q == IDLE) & req_decr & ~req_incr;
      fire_conf = (state_q == IDLE) & req_conf;
   end

   always_comb begin
      dest_onehot = '0;
      for (int i = 0; i < N_DEST; i++) begin
         dest_onehot[i] = (active_q == SEL_W'(i));
      end
   end

   // ---------------------------------------------------------------------------
   // Changeover FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      target_d = target_q;
      cnt_d    = cnt_q;

      dest_valid    = ({1'b0, bus.dest_sel} < N_DEST_L);
      sel_is_active = (bus.dest_sel == active_q);
      sel_is_target = (bus.dest_sel == target_q);

      case (state_q)
         IDLE: begin
            // Out-of-range selects are ignored rather than clamped.
            if (dest_valid && !sel_is_active) begin
               state_d  = SWITCH;
               target_d = bus.dest_sel;
               cnt_d    = CNT_LOAD;
            end
         end
         SWITCH: begin
            if (sel_is_active) begin
               // Select returned to the committed destination: abandon.
               state_d = IDLE;
            end else if (dest_valid && !sel_is_target) begin
               // New valid target mid-guard: restart the full guard.
               target_d = bus.dest_sel;
               cnt_d    = CNT_LOAD;
            end else if (cnt_q == '0) begin
               active_d = target_q;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Changeover FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         active_q <= '0;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // History, pulse and DT registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         incr_h <= 1'b0;
         decr_h <= 1'b0;
         conf_h <= 1'b0;
         incr_q <= '0;
         decr_q <= '0;
         conf_q <= '0;
         dt_q   <= '0;
      end else begin
         // History tracks the levels in every state, so a level held across
         // a changeover is consumed and never fires afterwards.
         incr_h <= bus.INCR;
         decr_h <= bus.DECR;
         conf_h <= bus.CONF;

         incr_q <= fire_incr ? dest_onehot : '0;
         decr_q <= fire_decr ? dest_onehot : '0;
         conf_q <= fire_conf ? dest_onehot : '0;

         for (int i = 0; i < N_DEST; i++) begin
            if (fire_conf && dest_onehot[i]) begin
               dt_q[i*DT_W +: DT_W] <= bus.DT;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.INCR_OUT    = incr_q;
   assign bus.DECR_OUT    = decr_q;
   assign bus.CONF_OUT    = conf_q;
   assign bus.DT_OUT      = dt_q;
   assign bus.active_dest = active_q;
   assign bus.busy        = (state_q == SWITCH);
   assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_cmd_router.sv
// -----------------------------------------------------------------------------
// tb_cmd_router
//   Drives cmd_router (N_DEST=3, SEL_W=2, so select value 3 is out of range)
//   with directed sequences followed by random traffic. A behavioural model
//   runs on every rising edge and queues the full expected output picture;
//   a monitor on the falling edge pops and compares it.
// -----------------------------------------------------------------------------
module tb_cmd_router;

   localparam int N_DEST    = 3;
   localparam int SEL_W     = 2;
   localparam int DT_W      = 5;
   localparam int GUARD_CYC = 4;
   localparam int W         = 3 * N_DEST + N_DEST * DT_W + SEL_W + 1;

   logic clk;
   logic rst;

   cmd_router_if #(.N_DEST(N_DEST), .SEL_W(SEL_W), .DT_W(DT_W)) bus ();

   cmd_router #(
      .N_DEST    (N_DEST),
      .SEL_W     (SEL_W),
      .DT_W      (DT_W),
      .GUARD_CYC (GUARD_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   int           n_tests;
   int           n_fail;

   // Reference model state: what the router "knows" in spec terms.
   bit               m_prev_incr, m_prev_decr, m_prev_conf;
   int               m_active;
   bit               m_switching;
   int               m_target;
   int               m_edges_left;
   logic [DT_W-1:0]  m_dt[N_DEST];

   function automatic logic [W-1:0] observed();
      return {bus.INCR_OUT, bus.DECR_OUT, bus.CONF_OUT, bus.DT_OUT,
              bus.active_dest, bus.busy};
   endfunction

   task automatic model_reset();
      m_prev_incr  = 0;
      m_prev_decr  = 0;
      m_prev_conf  = 0;
      m_active     = 0;
      m_switching  = 0;
      m_target     = 0;
      m_edges_left = 0;
      for (int k = 0; k < N_DEST; k++) m_dt[k] = '0;
   endtask

   // One rising edge of the reference behaviour; returns expected outputs.
   task automatic model_edge(output logic [W-1:0] exp_v);
      bit                     up_i, up_d, up_c;
      int                     sel;
      logic [N_DEST-1:0]      p_i, p_d, p_c;
      logic [N_DEST*DT_W-1:0] dt_flat;

      up_i = bus.INCR && !m_prev_incr;
      up_d = bus.DECR && !m_prev_decr;
      up_c = bus.CONF && !m_prev_conf;
      m_prev_incr = bus.INCR;
      m_prev_decr = bus.DECR;
      m_prev_conf = bus.CONF;
      sel = int'(bus.dest_sel);
      p_i = '0;
      p_d = '0;
      p_c = '0;

      if (!m_switching) begin
         if (up_c) begin
            p_c[m_active] = 1'b1;
            m_dt[m_active] = bus.DT;
         end
         if (up_i && !up_d) p_i[m_active] = 1'b1;
         if (up_d && !up_i) p_d[m_active] = 1'b1;
         if (sel < N_DEST && sel != m_active) begin
            m_switching  = 1;
            m_target     = sel;
            m_edges_left = GUARD_CYC - 1;
         end
      end else begin
         if (sel == m_active) begin
            m_switching = 0;
         end else if (sel < N_DEST && sel != m_target) begin
            m_target     = sel;
            m_edges_left = GUARD_CYC - 1;
         end else if (m_edges_left == 0) begin
            m_active    = m_target;
            m_switching = 0;
         end else begin
            m_edges_left = m_edges_left - 1;
         end
      end

      for (int k = 0; k < N_DEST; k++) dt_flat[k*DT_W +: DT_W] = m_dt[k];
      exp_v = {p_i, p_d, p_c, dt_flat, SEL_W'(m_active), m_switching};
   endtask

   task automatic model_loop();
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         if (rst) begin
            model_reset();
         end else begin
            model_edge(e);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic monitor_loop();
      logic [W-1:0] e;
      logic [W-1:0] g;
      forever begin
         @(negedge clk);
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = observed();
            n_tests++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, g, e);
            end
         end
      end
   endtask

   task automatic check_now(input string name, input logic [W-1:0] exp_v);
      logic [W-1:0] g;
      g = observed();
      n_tests++;
      if (g !== exp_v) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, g, exp_v);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic drive(input logic i, input logic d, input logic c,
                        input logic [SEL_W-1:0] s, input logic [DT_W-1:0] t);
      @(negedge clk);
      #1;
      bus.INCR     = i;
      bus.DECR     = d;
      bus.CONF     = c;
      bus.dest_sel = s;
      bus.DT       = t;
   endtask

   task automatic idle(input logic [SEL_W-1:0] s, input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, s, '0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic             r_i, r_d, r_c;
      logic [SEL_W-1:0] r_s;

      n_tests = 0;
      n_fail  = 0;
      model_reset();
      rst          = 1'b1;
      bus.INCR     = 1'b1;   // held through reset release: must fire once
      bus.DECR     = 1'b0;
      bus.CONF     = 1'b0;
      bus.dest_sel = '0;
      bus.DT       = '0;

      fork
         model_loop();
         monitor_loop();
      join_none

      #7;
      check_now("reset_state", '0);
      #1;
      rst = 1'b0;

      // Basic routing on destination 0: held INCR, then held DECR.
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 2'd0, '0);
      idle(2'd0, 2);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 2'd0, '0);
      idle(2'd0, 2);

      // DT latch on CONF, then a DT change without CONF.
      drive(1'b0, 1'b0, 1'b1, 2'd0, 5'd9);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd9);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd5);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd5);

      // Changeover 0 -> 1 with an INCR pulse during the guard, then after.
      drive(1'b0, 1'b0, 1'b0, 2'd1, '0);
      drive(1'b1, 1'b0, 1'b0, 2'd1, '0);
      drive(1'b0, 1'b0, 1'b0, 2'd1, '0);
      idle(2'd1, 4);
      drive(1'b1, 1'b0, 1'b0, 2'd1, '0);
      idle(2'd1, 2);

      // Retarget mid-guard: 1 -> 2, then 0 at guard cycle 2.
      idle(2'd2, 2);
      idle(2'd0, 7);
      // Abort: 0 -> 2, then back to 0 mid-guard.
      idle(2'd2, 2);
      idle(2'd0, 3);
      // Out-of-range select in IDLE and during a guard.
      idle(2'd3, 4);
      idle(2'd1, 1);
      idle(2'd3, 6);

      // INCR/DECR conflict with a coincident CONF.
      drive(1'b1, 1'b1, 1'b1, 2'd3, 5'd17);
      drive(1'b1, 1'b1, 1'b0, 2'd3, 5'd17);
      idle(2'd3, 2);
      // Level held across a guard must not fire afterwards.
      drive(1'b0, 1'b0, 1'b0, 2'd2, '0);
      for (int k = 0; k < 7; k++) drive(1'b0, 1'b1, 1'b0, 2'd2, '0);
      idle(2'd2, 2);

      // Asynchronous reset between edges in the middle of a changeover.
      idle(2'd0, 1);
      idle(2'd0, 2);
      idle(2'd1, 2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      check_now("async_reset_mid_switch", '0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      idle(2'd1, 6);

      // Random traffic.
      r_i = 0;
      r_d = 0;
      r_c = 0;
      r_s = 2'd1;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) r_i = ~r_i;
         if ($urandom_range(0, 3) == 0) r_d = ~r_d;
         if ($urandom_range(0, 4) == 0) r_c = ~r_c;
         if ($urandom_range(0, 11) == 0) r_s = SEL_W'($urandom_range(0, 3));
         drive(r_i, r_d, r_c, r_s, DT_W'($urandom_range(0, 31)));
      end
      idle(r_s, 3);

      @(negedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
